axis_bram_slave: RTL and testbench

// - AXI stream slave feeding the FFT input memory: accepts one frame of FFT_SIZE samples, writes

---
 rtl/axis_bram_slave.sv | 98 +++++++++
 tb/tb_axis_bram_slave.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_slave.sv
// AXI stream slave that collects one FFT frame into the sample BRAM and then
// starts the FFT core. The stream is held off while the core owns the memory.
module axis_bram_slave #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FFT_SIZE     = 4096,
  parameter int REAL_INPUT   = 1,
  parameter int BIT_REVERSE  = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [2*SAMPLE_WIDTH-1:0]     s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic [$clog2(FFT_SIZE)-1:0]   axis_s2mem_waddr,
  output logic [2*SAMPLE_WIDTH-1:0]     axis_s2mem_wdata,
  output logic                          axis_s2mem_wen,
  output logic                          fft_go,
  input  logic                          fft_busy,
  output logic                          axis_bram_slave_busy,
  output logic                          frame_err
);

  localparam int DATA_WIDTH = 2 * SAMPLE_WIDTH;
  localparam int ADDR_WIDTH = $clog2(FFT_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(FFT_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] KEEP_MASK =
    (REAL_INPUT != 0) ? {{SAMPLE_WIDTH{1'b1}}, {SAMPLE_WIDTH{1'b0}}} : {DATA_WIDTH{1'b1}};

  typedef enum logic [3:0] {
    FILL       = 4'b0001,
    GO         = 4'b0010,
    WAIT_START = 4'b0100,
    WAIT_DONE  = 4'b1000
  } state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   count_reg;
  logic [ADDR_WIDTH-1:0]   count_rev;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   wdata_next;
  logic                    handshake;
  logic                    at_last;

  genvar gi;
  for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_rev
    assign count_rev[gi] = count_reg[ADDR_WIDTH-1-gi];
  end

  // tready is gated by reset_n so it stays low while reset is held.
  assign s_axis_tready        = (state_reg == FILL) & reset_n;
  assign handshake            = s_axis_tvalid & s_axis_tready;
  assign at_last              = (count_reg == LAST_INDEX);
  assign addr_next            = (BIT_REVERSE != 0) ? count_rev : count_reg;
  assign wdata_next           = s_axis_tdata & KEEP_MASK;
  assign fft_go               = (state_reg == GO);
  assign axis_bram_slave_busy = !((state_reg == FILL) && (count_reg == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= FILL;
      count_reg        <= '0;
      axis_s2mem_wen   <= 1'b0;
      axis_s2mem_waddr <= '0;
      axis_s2mem_wdata <= '0;
      frame_err        <= 1'b0;
    end else begin
      axis_s2mem_wen <= handshake;
      frame_err      <= 1'b0;
      if (handshake) begin
        axis_s2mem_waddr <= addr_next;
        axis_s2mem_wdata <= wdata_next;
      end
      case (state_reg)
        FILL: begin
          if (handshake) begin
            if (at_last) begin
              // A missing tlast is flagged, but the full frame still goes out.
              state_reg <= GO;
              count_reg <= '0;
              frame_err <= ~s_axis_tlast;
            end else if (s_axis_tlast) begin
              count_reg <= '0;
              frame_err <= 1'b1;
            end else begin
              count_reg <= count_reg + ADDR_WIDTH'(1);
            end
          end
        end
        GO:         state_reg <= WAIT_START;
        WAIT_START: if (fft_busy)  state_reg <= WAIT_DONE;
        WAIT_DONE:  if (!fft_busy) state_reg <= FILL;
        default:    state_reg <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bram_slave.sv
// Randomized bench for axis_bram_slave: two instances (real/bit-reversed and
// complex/natural) share one stream and are compared every cycle to a frame model.
module tb_axis_bram_slave;

  localparam int N   = 16;
  localparam int LOG = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        fft_busy = 1'b0;

  logic        rb_tready, rb_wen, rb_go, rb_busy, rb_err;
  logic [3:0]  rb_waddr;
  logic [31:0] rb_wdata;
  logic        cn_tready, cn_wen, cn_go, cn_busy, cn_err;
  logic [3:0]  cn_waddr;
  logic [31:0] cn_wdata;

  always #5 clk = ~clk;

  axis_bram_slave #(.SAMPLE_WIDTH(16), .FFT_SIZE(N), .REAL_INPUT(1), .BIT_REVERSE(1)) dut_rb (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(tvalid), .s_axis_tready(rb_tready), .s_axis_tdata(tdata), .s_axis_tlast(tlast),
    .axis_s2mem_waddr(rb_waddr), .axis_s2mem_wdata(rb_wdata), .axis_s2mem_wen(rb_wen),
    .fft_go(rb_go), .fft_busy(fft_busy), .axis_bram_slave_busy(rb_busy), .frame_err(rb_err)
  );

  axis_bram_slave #(.SAMPLE_WIDTH(16), .FFT_SIZE(N), .REAL_INPUT(0), .BIT_REVERSE(0)) dut_cn (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(tvalid), .s_axis_tready(cn_tready), .s_axis_tdata(tdata), .s_axis_tlast(tlast),
    .axis_s2mem_waddr(cn_waddr), .axis_s2mem_wdata(cn_wdata), .axis_s2mem_wen(cn_wen),
    .fft_go(cn_go), .fft_busy(fft_busy), .axis_bram_slave_busy(cn_busy), .frame_err(cn_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Frame model: position in frame, and who owns memory (0 stream, 1 go, 2 wait start, 3 wait done).
  int          m_idx = 0;
  int          m_phase = 0;
  bit          m_in_reset = 1'b1;
  bit          last_hs = 1'b0;
  bit          e_wen = 1'b0, e_err = 1'b0;
  logic [3:0]  e_addr_rb, e_addr_cn;
  logic [31:0] e_data_rb, e_data_cn;
  int          fft_len = 3;
  int          fft_left = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bitrev(input int i);
    int r = 0;
    for (int b = 0; b < LOG; b++) r = r * 2 + ((i >> b) & 1);
    return r;
  endfunction

  task automatic check_outputs();
    bit e_tready = !m_in_reset && (m_phase == 0);
    bit e_go     = !m_in_reset && (m_phase == 1);
    bit e_busy   = !m_in_reset && !(m_phase == 0 && m_idx == 0);
    chk("rb_tready", rb_tready, e_tready);
    chk("cn_tready", cn_tready, e_tready);
    chk("rb_go", rb_go, e_go);
    chk("cn_go", cn_go, e_go);
    chk("rb_busy", rb_busy, e_busy);
    chk("cn_busy", cn_busy, e_busy);
    chk("rb_err", rb_err, e_err);
    chk("cn_err", cn_err, e_err);
    chk("rb_wen", rb_wen, e_wen);
    chk("cn_wen", cn_wen, e_wen);
    if (e_wen) begin
      chk("rb_waddr", rb_waddr, e_addr_rb);
      chk("cn_waddr", cn_waddr, e_addr_cn);
      chk("rb_wdata", rb_wdata, e_data_rb);
      chk("cn_wdata", cn_wdata, e_data_cn);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the next edge, then check.
  task automatic tick(input logic v, input logic [31:0] d, input logic l);
    bit hs;
    tvalid   = v;
    tdata    = d;
    tlast    = l;
    fft_busy = (fft_left > 0);
    hs = v && (m_phase == 0);
    e_wen = hs;
    e_err = 1'b0;
    if (hs) begin
      e_addr_rb = 4'(bitrev(m_idx));
      e_addr_cn = 4'(m_idx);
      e_data_rb = {d[31:16], 16'h0000};
      e_data_cn = d;
      e_err     = (l != (m_idx == N - 1));
    end
    case (m_phase)
      0: if (hs && m_idx == N - 1) m_phase = 1;
      1: m_phase = 2;
      2: if (fft_busy) m_phase = 3;
      default: if (!fft_busy) m_phase = 0;
    endcase
    if (hs) m_idx = (m_idx == N - 1 || l) ? 0 : m_idx + 1;
    if (fft_left > 0) fft_left--;
    if (m_phase == 1) fft_left = fft_len;
    last_hs = hs;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, 1'b0);
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int gap_pct);
    int tries = 0;
    for (int g = 0; g < 8; g++) begin
      if ($urandom_range(99) >= gap_pct) break;
      tick(1'b0, $urandom, 1'b0);
    end
    do begin
      tick(1'b1, d, l);
      tries++;
    end while (!last_hs && tries < 200);
    chk("handshake", last_hs, 1);
  endtask

  // mode 0: real part = sample index, random imag; mode 1: fully random sample.
  task automatic send_frame(input int n, input int last_at, input int mode, input int gap_pct);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = (mode == 0) ? {16'(i), 16'($urandom)} : 32'($urandom);
      send(d, (i == last_at), gap_pct);
    end
  endtask

  task automatic reset_mid();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_rb_wen", rb_wen, 0);
    chk("rst_cn_wen", cn_wen, 0);
    chk("rst_rb_go", rb_go, 0);
    chk("rst_rb_err", rb_err, 0);
    chk("rst_rb_tready", rb_tready, 0);
    chk("rst_rb_busy", rb_busy, 0);
    m_in_reset = 1'b1;
    m_idx = 0;
    m_phase = 0;
    e_wen = 1'b0;
    e_err = 1'b0;
    fft_left = 0;
    tvalid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_in_reset = 1'b0;
    #1;
    chk("rel_rb_tready", rb_tready, 1);
    chk("rel_cn_tready", cn_tready, 1);
    chk("rel_rb_busy", rb_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("init_rb_waddr", rb_waddr, 0);
    chk("init_rb_wdata", rb_wdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_in_reset = 1'b0;
    #1;
    check_outputs();

    // Partial frame cut by an asynchronous reset while a write is in flight.
    send_frame(6, -1, 0, 0);
    reset_mid();

    // Continuous frame, bit-reversed real writes.
    fft_len = 3;
    send_frame(N, N - 1, 0, 0);
    idle(8);

    // Long FFT busy with the next frame already offered during the stall.
    fft_len = 20;
    send_frame(N, N - 1, 1, 0);
    send_frame(N, N - 1, 1, 0);
    fft_len = 4;
    idle(30);

    // Early tlast, then a full frame.
    send_frame(6, 5, 0, 0);
    send_frame(N, N - 1, 0, 0);
    idle(12);

    // Missing tlast still dispatches.
    send_frame(N, -1, 0, 0);
    idle(12);

    // Random gaps, random complex data.
    fft_len = 6;
    send_frame(N, N - 1, 1, 50);
    send_frame(N, N - 1, 1, 50);
    idle(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
